// File: rtl/rv32i_test_monitor.sv
// rv32i_test_monitor
//   Detects the end of a test on the rv32i_soc core and reports its outcome
//   using the riscv-tests convention. It watches instruction retirement,
//   register-file writeback and data-memory writes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   inst_valid, inst_q       retiring instruction strobe and word
//   rf_wr/addr/data          base-register writeback port
//   dm_wr/addr/data/mask     data-memory write port
//   done                     test finished with any outcome (sticky)
//   pass/fail/unknown/timeout  outcome flags, one-hot while done
//   exit_code                status code (code >> 1, or all-ones on timeout)
//   cycle_cnt, instret_cnt   saturating run-cycle and retired-instruction counts
module rv32i_test_monitor #(
  parameter int              XLEN           = 32,
  parameter logic [31:0]     HALT_INST      = 32'h0010_0073,
  parameter int              EXIT_MODE      = 0,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 'h0000_1000,
  parameter int              ID_REG         = 17,
  parameter logic [XLEN-1:0] EXIT_ID        = 'h5d,
  parameter int              CODE_REG       = 10,
  parameter int              TIMEOUT_CYCLES = 1000000,
  parameter int              CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic [31:0]       inst_q,
  input  logic              rf_wr,
  input  logic [4:0]        rf_addr,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              dm_wr,
  input  logic [XLEN-1:0]   dm_addr,
  input  logic [XLEN-1:0]   dm_data,
  input  logic [XLEN/8-1:0] dm_mask,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              unknown,
  output logic              timeout,
  output logic [XLEN-1:0]   exit_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  localparam bit HALT_EN   = (EXIT_MODE == 0) || (EXIT_MODE == 2);
  localparam bit TOHOST_EN = (EXIT_MODE == 1) || (EXIT_MODE == 2);
  localparam bit TO_EN     = (TIMEOUT_CYCLES != 0);
  // Only meaningful when TO_EN; the wrap for 0 is never compared.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_RUN, S_PASS, S_FAIL, S_UNKNOWN, S_TIMEOUT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   exit_code_q, exit_code_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instret_cnt_q, instret_cnt_d;
  logic [XLEN-1:0]   id_sh_q, id_sh_d;
  logic [XLEN-1:0]   code_sh_q, code_sh_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              unknown_q, unknown_d;
  logic              timeout_q, timeout_d;

  logic              running;
  logic              id_wr, code_wr;
  logic [XLEN-1:0]   id_eff, code_eff;
  logic              halt_evt, tohost_evt;

  assign running = (state_q == S_RUN);

  // x0 is hardwired, so a write naming it never lands in a shadow.
  assign id_wr   = rf_wr && (rf_addr != 5'd0) && (rf_addr == 5'(ID_REG));
  assign code_wr = rf_wr && (rf_addr != 5'd0) && (rf_addr == 5'(CODE_REG));

  // Bypass: a writeback retiring alongside the halt is already architectural.
  assign id_eff   = id_wr   ? rf_data : id_sh_q;
  assign code_eff = code_wr ? rf_data : code_sh_q;

  assign halt_evt   = HALT_EN && inst_valid && (inst_q == HALT_INST);
  // A tohost word only signals exit when fully written with bit 0 set.
  assign tohost_evt = TOHOST_EN && dm_wr && (dm_addr == TOHOST_ADDR) &&
                      (&dm_mask) && dm_data[0];

  // State register and all registered datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      exit_code_q   <= '0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
      id_sh_q       <= '0;
      code_sh_q     <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      unknown_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      exit_code_q   <= exit_code_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
      id_sh_q       <= id_sh_d;
      code_sh_q     <= code_sh_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      unknown_q     <= unknown_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next state. Priority: tohost, then halt, then watchdog.
  always_comb begin
    state_d     = state_q;
    exit_code_d = exit_code_q;
    if (running) begin
      if (tohost_evt) begin
        state_d     = (dm_data == XLEN'(1)) ? S_PASS : S_FAIL;
        exit_code_d = dm_data >> 1;
      end else if (halt_evt) begin
        if (id_eff != EXIT_ID)    state_d = S_UNKNOWN;
        else if (code_eff == '0)  state_d = S_PASS;
        else                      state_d = S_FAIL;
        exit_code_d = code_eff >> 1;
      end else if (TO_EN && (cycle_cnt_q == TO_LAST)) begin
        state_d     = S_TIMEOUT;
        exit_code_d = '1;
      end
    end
  end

  // Outputs, decoded from the next state so they land in flops together.
  always_comb begin
    done_d    = (state_d != S_RUN);
    pass_d    = (state_d == S_PASS);
    fail_d    = (state_d == S_FAIL);
    unknown_d = (state_d == S_UNKNOWN);
    timeout_d = (state_d == S_TIMEOUT);
  end

  // Counters and shadows only move while running; end states freeze them.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    id_sh_d       = id_sh_q;
    code_sh_d     = code_sh_q;
    if (running) begin
      if (cycle_cnt_q != '1)
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (inst_valid && (instret_cnt_q != '1))
        instret_cnt_d = instret_cnt_q + CNT_W'(1);
      if (id_wr)   id_sh_d   = rf_data;
      if (code_wr) code_sh_d = rf_data;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign unknown     = unknown_q;
  assign timeout     = timeout_q;
  assign exit_code   = exit_code_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_rv32i_test_monitor.sv
// Bench for rv32i_test_monitor. Two instances share one stimulus stream:
//   dut 0: EXIT_MODE=2 (halt or tohost), TIMEOUT_CYCLES=50
//   dut 1: EXIT_MODE=0 (halt only),      watchdog disabled
// A run-level reference model pushes the expected outcome when it decides a
// test has ended; a monitor pops and compares when the DUT raises done.
module tb_rv32i_test_monitor;

  localparam logic [31:0] HALT = 32'h0010_0073;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  typedef struct {
    bit          p, f, u, t;
    logic [31:0] code, cyc, ret;
  } exp_t;

  logic clk, rst;
  logic inst_valid;
  logic [31:0] inst_q;
  logic rf_wr;
  logic [4:0] rf_addr;
  logic [31:0] rf_data;
  logic dm_wr;
  logic [31:0] dm_addr, dm_data;
  logic [3:0] dm_mask;

  logic [1:0] done, pass, fail, unknown, timeout;
  logic [1:0][31:0] exit_code, cycle_cnt, instret_cnt;

  rv32i_test_monitor #(.EXIT_MODE(2), .TIMEOUT_CYCLES(50)) dut_a (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_q(inst_q),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_data(dm_data), .dm_mask(dm_mask),
    .done(done[0]), .pass(pass[0]), .fail(fail[0]), .unknown(unknown[0]),
    .timeout(timeout[0]), .exit_code(exit_code[0]), .cycle_cnt(cycle_cnt[0]),
    .instret_cnt(instret_cnt[0]));

  rv32i_test_monitor #(.EXIT_MODE(0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_q(inst_q),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_data(dm_data), .dm_mask(dm_mask),
    .done(done[1]), .pass(pass[1]), .fail(fail[1]), .unknown(unknown[1]),
    .timeout(timeout[1]), .exit_code(exit_code[1]), .cycle_cnt(cycle_cnt[1]),
    .instret_cnt(instret_cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  // Reference model state, one set per instance.
  int          m_mode [2] = '{2, 0};
  int          m_to   [2] = '{50, 0};
  bit          m_end  [2];
  logic [31:0] m_id [2], m_code [2], m_cyc [2], m_ret [2];
  exp_t        m_last [2];
  bit          seen [2];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic int sb_size(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic sb_push(input int k, input exp_t e);
    if (k == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  task automatic sb_pop(input int k, output exp_t e);
    if (k == 0) e = sb0.pop_front(); else e = sb1.pop_front();
  endtask

  task automatic cmp_exp(input string tag, input int k, input exp_t e);
    check({tag, "_done"},    k, 32'(done[k]), 32'd1);
    check({tag, "_pass"},    k, 32'(pass[k]), 32'(e.p));
    check({tag, "_fail"},    k, 32'(fail[k]), 32'(e.f));
    check({tag, "_unknown"}, k, 32'(unknown[k]), 32'(e.u));
    check({tag, "_timeout"}, k, 32'(timeout[k]), 32'(e.t));
    check({tag, "_exit_code"}, k, exit_code[k], e.code);
    check({tag, "_cycle_cnt"}, k, cycle_cnt[k], e.cyc);
    check({tag, "_instret"},   k, instret_cnt[k], e.ret);
  endtask

  // One cycle of the model, from the rules: tohost beats halt beats watchdog.
  task automatic model_step(input int k);
    exp_t e;
    logic [31:0] id_e, code_e;
    bit halt, th, ended;
    if (m_end[k]) return;
    id_e   = (rf_wr && rf_addr == 5'd17) ? rf_data : m_id[k];
    code_e = (rf_wr && rf_addr == 5'd10) ? rf_data : m_code[k];
    halt = inst_valid && inst_q == HALT && m_mode[k] != 1;
    th   = dm_wr && dm_addr == TOHOST && dm_mask == 4'hf && dm_data[0] && m_mode[k] != 0;
    e = '{default: '0};
    ended = 1'b1;
    if (th) begin
      e.p = (dm_data == 32'd1); e.f = !e.p; e.code = dm_data / 2;
    end else if (halt) begin
      e.u = (id_e != 32'h5d);
      e.p = !e.u && code_e == 0;
      e.f = !e.u && code_e != 0;
      e.code = code_e / 2;
    end else if (m_to[k] != 0 && m_cyc[k] == 32'(m_to[k] - 1)) begin
      e.t = 1'b1; e.code = 32'hffff_ffff;
    end else ended = 1'b0;
    m_cyc[k] = m_cyc[k] + 1;
    if (inst_valid) m_ret[k] = m_ret[k] + 1;
    if (rf_wr && rf_addr == 5'd17) m_id[k] = rf_data;
    if (rf_wr && rf_addr == 5'd10) m_code[k] = rf_data;
    if (ended) begin
      e.cyc = m_cyc[k]; e.ret = m_ret[k];
      m_end[k] = 1'b1; m_last[k] = e;
      sb_push(k, e);
    end
  endtask

  task automatic set_idle();
    inst_valid = 0; inst_q = 32'h0000_0013;
    rf_wr = 0; rf_addr = 0; rf_data = 0;
    dm_wr = 0; dm_addr = 0; dm_data = 0; dm_mask = 0;
  endtask

  // Inputs are set at negedge+1; the model sees exactly what the DUT samples.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(negedge clk); #1;
    set_idle();
  endtask

  task automatic do_reset();
    exp_t e;
    set_idle();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_flags", k, 32'({done[k], pass[k], fail[k], unknown[k], timeout[k]}), 32'd0);
      check("rst_exit_code", k, exit_code[k], 32'd0);
      check("rst_cycle_cnt", k, cycle_cnt[k], 32'd0);
      check("rst_instret", k, instret_cnt[k], 32'd0);
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_end[k] = 0; m_id[k] = 0; m_code[k] = 0; m_cyc[k] = 0; m_ret[k] = 0;
      while (sb_size(k) != 0) sb_pop(k, e);
    end
    rst = 1'b0;
  endtask

  // Ended instances must hold their outcome; running ones must not be done.
  task automatic end_check();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (sb_size(k) != 0) begin
        check("missing_done", k, 32'(done[k]), 32'd1);
        while (sb_size(k) != 0) sb_pop(k, e);
      end
      if (m_end[k]) cmp_exp("frozen", k, m_last[k]);
      else begin
        check("running_done", k, 32'(done[k]), 32'd0);
        check("running_cycle_cnt", k, cycle_cnt[k], m_cyc[k]);
        check("running_instret", k, instret_cnt[k], m_ret[k]);
      end
    end
  endtask

  task automatic rfw(input logic [4:0] a, input logic [31:0] d);
    rf_wr = 1; rf_addr = a; rf_data = d;
  endtask

  task automatic dmw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    dm_wr = 1; dm_addr = a; dm_data = d; dm_mask = m;
  endtask

  task automatic do_halt();
    inst_valid = 1; inst_q = HALT;
  endtask

  task automatic idle_ticks(input int n, input bit rand_inst);
    for (int i = 0; i < n; i++) begin
      if (rand_inst) begin
        inst_valid = 1'($urandom_range(0, 1));
        inst_q = $urandom;
        if (inst_q == HALT) inst_q = inst_q ^ 32'h1;
      end
      tick();
    end
  endtask

  task automatic rand_cycle();
    int r;
    inst_valid = ($urandom_range(0, 3) != 0);
    inst_q = $urandom;
    if (inst_q == HALT) inst_q = inst_q ^ 32'h1;
    if ($urandom_range(0, 29) == 0) inst_q = HALT;
    rf_wr = ($urandom_range(0, 2) == 0);
    r = $urandom_range(0, 3);
    rf_addr = (r == 0) ? 5'd0 : (r == 1) ? 5'd10 : (r == 2) ? 5'd17 : 5'($urandom);
    r = $urandom_range(0, 3);
    rf_data = (r == 0) ? 32'd0 : (r == 1) ? 32'h5d : (r == 2) ? 32'($urandom_range(1, 9)) : $urandom;
    dm_wr = ($urandom_range(0, 3) == 0);
    dm_addr = $urandom_range(0, 1) ? TOHOST : $urandom;
    dm_mask = $urandom_range(0, 1) ? 4'hf : 4'($urandom);
    r = $urandom_range(0, 2);
    dm_data = (r == 0) ? 32'd1 : (r == 1) ? ($urandom | 32'd1) : $urandom;
  endtask

  // Monitor: compares whenever a DUT newly presents done.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      for (int k = 0; k < 2; k++) begin
        if (rst) seen[k] = 0;
        else if (done[k] && !seen[k]) begin
          seen[k] = 1;
          if (sb_size(k) == 0) check("unexpected_done", k, 32'(done[k]), 32'd0);
          else begin
            sb_pop(k, e);
            cmp_exp("outcome", k, e);
          end
        end else if (!done[k] && seen[k]) begin
          check("done_sticky", k, 32'(done[k]), 32'd1);
          seen[k] = 0;
        end else if (!done[k] && sb_size(k) != 0) begin
          check("done_late", k, 32'(done[k]), 32'd1);
          sb_pop(k, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: run did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    set_idle();
    rst = 1'b1;
    do_reset();

    // Plain pass.
    rfw(17, 32'h5d); tick();
    rfw(10, 32'h0); tick();
    do_halt(); tick();
    idle_ticks(3, 0); end_check(); do_reset();

    // Code written in the halt cycle must be bypassed.
    rfw(17, 32'h5d); tick();
    do_halt(); rfw(10, 32'h7); tick();
    idle_ticks(3, 0); end_check(); do_reset();

    // Wrong exit id -> unknown.
    rfw(17, 32'h0); tick();
    do_halt(); tick();
    idle_ticks(3, 0); end_check(); do_reset();

    // Ignored tohost writes, then tohost and halt together.
    rfw(17, 32'h5d); tick();
    rfw(10, 32'h6); tick();
    dmw(TOHOST, 32'h1, 4'b0011); tick();
    dmw(TOHOST, 32'h4, 4'b1111); tick();
    dmw(TOHOST, 32'h1, 4'b1111); do_halt(); tick();
    idle_ticks(3, 0); end_check(); do_reset();

    // Watchdog expiry with no exit.
    idle_ticks(60, 1); end_check(); do_reset();

    // Halt on the last watchdog cycle beats the timeout.
    rfw(17, 32'h5d); tick();
    idle_ticks(48, 0);
    do_halt(); tick();
    idle_ticks(3, 0); end_check(); do_reset();

    // Reset out of PASS, then a fresh failing run.
    rfw(17, 32'h5d); tick();
    do_halt(); tick();
    idle_ticks(2, 0); end_check(); do_reset();
    rfw(17, 32'h5d); tick();
    rfw(10, 32'h2); tick();
    idle_ticks(4, 1);
    do_halt(); tick();
    idle_ticks(3, 0); end_check(); do_reset();

    // Randomized runs.
    for (int run = 0; run < 25; run++) begin
      for (int c = 0; c < 80; c++) begin
        if (m_end[0] && m_end[1]) break;
        rand_cycle();
        tick();
      end
      idle_ticks(3, 0);
      end_check();
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_test_monitor.md
Name: rv32i_test_monitor

Overview:
- Synthesizable test-completion monitor for the rv32i_soc core; replaces bench-side halt/pass/fail logic so the same check runs in simulation, FPGA and emulation.
- Snoops instruction fetch, base-register writeback and data-memory write ports.
- Detects the end of a test by halt instruction (ebreak), a write to a tohost address, or both.
- Reports pass/fail/unknown/timeout using the riscv-tests convention, with an exit code and cycle and retired-instruction counters.

Parameters:
- XLEN, 32, datapath width.
- HALT_INST, 32'h00100073, instruction encoding that ends the test.
- EXIT_MODE, 0, 0 = halt instruction only; 1 = tohost write only; 2 = whichever occurs first.
- TOHOST_ADDR, 32'h0000_1000, data address of the tohost word.
- ID_REG, 17, register index holding the exit-call id (a7).
- EXIT_ID, 32'h5d, id value required for a valid exit.
- CODE_REG, 10, register index holding the exit status (a0).
- TIMEOUT_CYCLES, 1000000, run-cycle limit; 0 disables the watchdog.
- CNT_W, 32, width of the cycle and instret counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- inst_valid  in  1  inst_q holds a retiring instruction this cycle
- inst_q  in  32  instruction word
- rf_wr  in  1  base-register write strobe
- rf_addr  in  5  destination register index
- rf_data  in  XLEN  write data
- dm_wr  in  1  data-memory write strobe
- dm_addr  in  XLEN  byte address
- dm_data  in  XLEN  write data
- dm_mask  in  XLEN/8  byte-enable mask
- done  out  1  test finished (any outcome); sticky
- pass  out  1  finished with pass
- fail  out  1  finished with fail
- unknown  out  1  halted, but ID_REG != EXIT_ID
- timeout  out  1  watchdog expired
- exit_code  out  XLEN  reported status code
- cycle_cnt  out  CNT_W  cycles spent in RUN
- instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async on rst=1): state=RUN; all outputs 0; shadow registers id_sh and code_sh cleared to 0.
- States: RUN, PASS, FAIL, UNKNOWN, TIMEOUT.
  - The four end states are terminal; only rst leaves them.
  - done = state != RUN.
  - Each flag is high only in its own state.
- Shadow registers:
  - On rf_wr with rf_addr==ID_REG, id_sh <= rf_data.
  - On rf_wr with rf_addr==CODE_REG, code_sh <= rf_data.
  - rf_addr==0 is always ignored.
- Same-cycle bypass: exit evaluation uses rf_data if a matching write happens in the same cycle as the halt instruction.
- Halt exit (EXIT_MODE 0 or 2): inst_valid && inst_q==HALT_INST while in RUN. The next cycle enters:
  - UNKNOWN if id != EXIT_ID;
  - PASS if id == EXIT_ID and code == 0;
  - FAIL otherwise.
  - exit_code = code >> 1 (logical shift).
- Tohost exit (EXIT_MODE 1 or 2): dm_wr && dm_addr==TOHOST_ADDR && dm_mask all-ones && dm_data[0]==1 while in RUN.
  - dm_data==1 -> PASS; otherwise -> FAIL.
  - exit_code = dm_data >> 1.
  - A write with dm_data[0]==0 is ignored, as is a partial-mask write.
- Simultaneous halt and tohost in mode 2: tohost wins.
- Watchdog:
  - cycle_cnt increments every cycle in RUN.
  - When TIMEOUT_CYCLES != 0 and cycle_cnt == TIMEOUT_CYCLES-1 with no exit event that cycle, the next state is TIMEOUT and exit_code = all-ones.
  - An exit event in the same cycle as expiry wins over the timeout.
- instret_cnt increments on inst_valid in RUN. The halt instruction itself is counted.
- Both counters saturate at all-ones and freeze in every end state.
- Latency: one cycle from the triggering event to done, flags and exit_code. All outputs are registered.
- Events after done are ignored. Counters and exit_code hold until reset.
- rst asserted mid-run clears everything immediately. Monitoring restarts on the first clk edge after release.

Test Plan:
- Mode 0: write x17=0x5d and x10=0, then halt 0x00100073 -> next cycle done=1, pass=1, exit_code=0.
- Mode 0: write x17=0x5d, then halt in the same cycle as rf_wr x10=0x7 -> fail=1, exit_code=0x3 (bypass verified).
- Mode 0: x17=0x00, then halt -> unknown=1, pass=0, fail=0.
- Mode 2: dm_wr 0x1000 data 0x1 mask 1111 in the same cycle as halt with x10=0x6 -> pass=1, exit_code=0 (tohost wins).
  - A prior write to 0x1000 with mask 0011 must be ignored.
- TIMEOUT_CYCLES=50, no exit event -> timeout=1 after cycle_cnt reaches 49, exit_code=0xFFFFFFFF, counters frozen.
  - Repeat with a halt on cycle 49 -> halt outcome, not timeout.
- Assert rst while in PASS state -> all outputs 0 asynchronously.
  - After release, a second run with x10=0x2 exits with fail=1, exit_code=1, and instret_cnt restarted from 0.
